serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor that computes A − B one bit per clock, LSB first, using a single half/full-subtract cell with a registered borrow.
It consumes the per-bit difference/borrow function of the half subtractor and chains the borrow across cycles.
It sits downstream of operand registers and upstream of result consumers.
A start/busy/done handshake trades latency for minimal logic.

---
 rtl/serial_subtractor.sv | 112 +++++++++++
 tb/tb_serial_subtractor.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B one bit per clock, LSB first, start/busy/done handshake.
// Optional signed-overflow output guarded by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_cat;
  logic             br, br_nxt, d;
  logic [CW-1:0]    cnt;
  logic             accept, last_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb, b_msb;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = (state == RUN);
    last_bit  = (cnt == CW'(WIDTH - 1));
    d         = a_sr[0] ^ b_sr[0] ^ br;
    br_nxt    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    // res holds the WIDTH-1 bits already produced; prepending d yields the full word.
    res_cat   = {d, res};
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sr <= a;
        b_sr <= b;
        br   <= 1'b0;
        cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
`endif
      end else if (state == RUN) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        br   <= br_nxt;
        res  <= res_cat[WIDTH-1:1];
        if (last_bit) begin
          diff       <= res_cat;
          borrow_out <= br_nxt;
          done       <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          ovf        <= (a_msb ^ b_msb) & (d ^ a_msb);
`endif
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); ovf checks only with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation, checks busy/done timing every cycle, then the results.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    logic [W-1:0] held;
    a = ai; b = bi; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'h5A; b = 8'hC3;
    held = diff;
    check("busy_t0", {31'd0, busy}, 32'd1);
    for (int unsigned i = 1; i < W; i++) begin
      tick();
      check("busy_run", {30'd0, busy, done}, 32'd2);
      check("diff_hold", {24'd0, diff}, {24'd0, held});
    end
    tick();
    check("done_pulse", {30'd0, busy, done}, 32'd1);
    check("diff", {24'd0, diff}, {24'd0, ed});
    check("borrow", {31'd0, borrow_out}, {31'd0, eb});
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", {31'd0, ovf}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("note: ovf expectation unknown");
`endif
    tick();
    check("done_drop", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    check("rst_state", {21'd0, busy, done, diff, borrow_out}, 32'd0);
    rst = 1'b0;
    tick();

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

    // start held high; operands change mid-run, second op accepted in the done cycle
    a = 8'h05; b = 8'h03; start = 1'b1;
    tick();
    a = 8'hAA; b = 8'h11;
    for (int unsigned i = 1; i < W; i++) begin
      tick();
      check("b2b_busy1", {30'd0, busy, done}, 32'd2);
    end
    tick();
    check("b2b_done1", {30'd0, busy, done}, 32'd1);
    check("b2b_diff1", {23'd0, borrow_out, diff}, 32'h002);
    tick();
    start = 1'b0;
    check("b2b_accept2", {30'd0, busy, done}, 32'd2);
    for (int unsigned i = 1; i < W; i++) begin
      tick();
      check("b2b_busy2", {30'd0, busy, done}, 32'd2);
    end
    tick();
    check("b2b_done2", {30'd0, busy, done}, 32'd1);
    check("b2b_diff2", {23'd0, borrow_out, diff}, 32'h099);
`ifdef SERIAL_SUB_OVF_EN
    check("b2b_ovf2", {31'd0, ovf}, 32'd0);
`endif
    tick();

    // reset mid-operation aborts with no done pulse
    a = 8'h80; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", {21'd0, busy, done, diff, borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("abort_ovf", {31'd0, ovf}, 32'd0);
`endif
    seen_done = 1'b0;
    for (int unsigned i = 0; i < 2 * W; i++) begin
      tick();
      if (done || busy) seen_done = 1'b1;
    end
    check("abort_quiet", {31'd0, seen_done}, 32'd0);

    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
